ex_div: RTL

//  RV32M divide unit in the EX stage, downstream of the operand-forwarding block.

---
 rtl/ex_div_pkg.sv | 30 +++
 rtl/ex_div.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/ex_div_pkg.sv
// Shared types, constants and sign helpers for the EX-stage RV32M divide unit.
package ex_div_pkg;

  localparam int unsigned DIV_ITER   = 32;
  localparam int unsigned CNT_W      = 6;
  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(DIV_ITER - 1);
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  typedef logic [1:0] DivOp_t;
  localparam DivOp_t OP_DIV  = 2'b00;
  localparam DivOp_t OP_DIVU = 2'b01;
  localparam DivOp_t OP_REM  = 2'b10;
  localparam DivOp_t OP_REMU = 2'b11;

  typedef logic [1:0] DivState_t;
  localparam DivState_t ST_IDLE = 2'd0;
  localparam DivState_t ST_CALC = 2'd1;
  localparam DivState_t ST_DONE = 2'd2;

  function automatic logic [31:0] neg32(input logic [31:0] x);
    return (~x) + 32'd1;
  endfunction

  function automatic logic [31:0] abs32(input logic [31:0] x);
    return x[31] ? neg32(x) : x;
  endfunction

endpackage

// File: rtl/ex_div.sv
// RV32M divide unit (DIV/DIVU/REM/REMU): radix-2 restoring divider, one quotient
// bit per clock, stalls the front of the pipe while iterating.
module ex_div
  import ex_div_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [1:0]            op_i,
  input  logic [DATA_W-1:0]     dividend_i,
  input  logic [DATA_W-1:0]     divisor_i,
  input  logic [REG_ADDR_W-1:0] waddr_i,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic                  stall_o,
  output logic                  valid_o,
  output logic [DATA_W-1:0]     result_o,
  output logic [REG_ADDR_W-1:0] waddr_o
);

  localparam logic [DATA_W-1:0] INT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  DivState_t             r_state;
  DivState_t             w_state_next;
  logic                  w_accept;

  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_W-1:0]     r_rem;
  logic [DATA_W-1:0]     r_quo;
  logic [DATA_W-1:0]     r_divisor;
  logic                  r_is_rem;
  logic                  r_neg_q;
  logic                  r_neg_r;
  logic [DATA_W-1:0]     r_result;
  logic [REG_ADDR_W-1:0] r_waddr;

  // Operand decode at accept time
  logic              w_signed;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [DATA_W-1:0] w_a_abs;
  logic [DATA_W-1:0] w_b_abs;
  logic              w_div0;
  logic              w_ovf;
  logic              w_special;
  logic [DATA_W-1:0] w_special_res;

  assign w_signed  = ~op_i[0];
  assign w_a_neg   = w_signed & dividend_i[DATA_W-1];
  assign w_b_neg   = w_signed & divisor_i[DATA_W-1];
  assign w_a_abs   = w_signed ? abs32(dividend_i) : dividend_i;
  assign w_b_abs   = w_signed ? abs32(divisor_i)  : divisor_i;
  assign w_div0    = (divisor_i == '0);
  assign w_ovf     = w_signed & (dividend_i == INT_MIN) & (divisor_i == '1);
  assign w_special = w_div0 | w_ovf;

  always_comb begin
    w_special_res = '0;
    if (w_div0) begin
      w_special_res = op_i[1] ? dividend_i : '1;
    end else if (w_ovf) begin
      w_special_res = op_i[1] ? '0 : INT_MIN;
    end
  end

  // One restoring step; the 33-bit difference's MSB is the borrow
  logic [DATA_W:0]   w_rem_sh;
  logic [DATA_W:0]   w_diff;
  logic              w_ge;
  logic [DATA_W-1:0] w_rem_next;
  logic [DATA_W-1:0] w_quo_next;
  logic [DATA_W-1:0] w_fix_res;

  assign w_rem_sh   = {r_rem, r_quo[DATA_W-1]};
  assign w_diff     = w_rem_sh - {1'b0, r_divisor};
  assign w_ge       = ~w_diff[DATA_W];
  assign w_rem_next = w_ge ? w_diff[DATA_W-1:0] : w_rem_sh[DATA_W-1:0];
  assign w_quo_next = {r_quo[DATA_W-2:0], w_ge};
  assign w_fix_res  = r_is_rem ? (r_neg_r ? neg32(w_rem_next) : w_rem_next)
                               : (r_neg_q ? neg32(w_quo_next) : w_quo_next);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and pipeline handshake; flush outranks everything
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    busy_o       = 1'b0;
    stall_o      = 1'b0;
    valid_o      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_i && !flush_i) begin
          w_accept     = 1'b1;
          w_state_next = w_special ? ST_DONE : ST_CALC;
          stall_o      = ~rst;
        end
      end
      ST_CALC: begin
        busy_o  = 1'b1;
        stall_o = 1'b1;
        if (r_cnt == LAST_CNT) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        busy_o       = 1'b1;
        valid_o      = ~flush_i;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
    if (flush_i) begin
      w_state_next = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_is_rem  <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_result  <= '0;
      r_waddr   <= ZERO_REG;
    end else if (w_accept) begin
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= w_a_abs;
      r_divisor <= w_b_abs;
      r_is_rem  <= op_i[1];
      r_neg_q   <= w_a_neg ^ w_b_neg;
      r_neg_r   <= w_a_neg;
      r_waddr   <= waddr_i;
      if (w_special) begin
        r_result <= w_special_res;
      end
    end else if (r_state == ST_CALC && !flush_i) begin
      r_rem <= w_rem_next;
      r_quo <= w_quo_next;
      r_cnt <= r_cnt + CNT_W'(1);
      if (r_cnt == LAST_CNT) begin
        r_result <= w_fix_res;
      end
    end
  end

  assign result_o = r_result;
  assign waddr_o  = r_waddr;

endmodule
